// File: rtl/reg_write_arbiter.sv
// -----------------------------------------------------------------------------
// reg_write_arbiter
//   Round-robin arbiter sharing the d/ce write port of one register_16 among
//   N_REQ requesters. At most one requester wins per edge. Its data is
//   forwarded with a one-cycle ce pulse, and a registered one-hot grant is
//   returned. A requester holding lock keeps the port for a burst of up to
//   MAX_BURST back-to-back writes.
//
// Handshake: a requester raises req with stable wdata and holds both until
//   it sees its gnt bit. gnt high in cycle C means the wdata sampled at the
//   edge that starts C is being written (reg_d/reg_ce in the same cycle).
//   The requester granted at edge E is skipped at edge E+1 unless its burst
//   continues. This lets it drop req on seeing gnt without a second write.
//
// Ports:
//   clk    in   rising-edge clock
//   clr    in   synchronous active-high reset, priority over everything
//   req    in   [N_REQ]        per-requester write request (level)
//   lock   in   [N_REQ]        per-requester burst hold (qualifies req)
//   wdata  in   [N_REQ*WIDTH]  requester i data at [i*WIDTH +: WIDTH]
//   gnt    out  [N_REQ]        registered one-hot grant, zero when idle
//   reg_d  out  [WIDTH]        data to register_16.d
//   reg_ce out                 enable to register_16.ce
//   owner  out  [3]            index of current / last granted requester
//   busy   out                 high while in the LOCKED state
// -----------------------------------------------------------------------------
module reg_write_arbiter #(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 16,
  parameter int MAX_BURST = 8
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ-1:0]       lock,
  input  logic [N_REQ*WIDTH-1:0] wdata,
  output logic [N_REQ-1:0]       gnt,
  output logic [WIDTH-1:0]       reg_d,
  output logic                   reg_ce,
  output logic [2:0]             owner,
  output logic                   busy
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [WIDTH-1:0]  reg_d_q, reg_d_d;
  logic              reg_ce_q, reg_ce_d;
  logic [2:0]        owner_q, owner_d;

  logic [N_REQ-1:0]  cand;
  logic              found;
  logic [PW-1:0]     win;
  logic [PW-1:0]     own;
  logic              keep;

  assign own = owner_q[PW-1:0];

  // The registered grant is exactly the requester granted at the previous
  // edge, so it doubles as the one-edge arbitration mask. During a burst
  // continuation the mask is bypassed through the keep path instead.
  always_comb begin : p_arb
    int idx;
    cand  = req & ~gnt_q;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && cand[idx]) begin
        found = 1'b1;
        win   = idx[PW-1:0];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    gnt_d    = '0;
    reg_d_d  = reg_d_q;
    reg_ce_d = 1'b0;
    owner_d  = owner_q;

    keep = (state_q == S_LOCKED) && req[own] && lock[own] &&
           (cnt_q < 4'(MAX_BURST));

    if (keep) begin
      gnt_d    = gnt_q;
      reg_d_d  = wdata[int'(own)*WIDTH +: WIDTH];
      reg_ce_d = 1'b1;
      cnt_d    = cnt_q + 4'd1;
    end else begin
      // Idle arbitration; also the release path of a burst, where the
      // outgoing owner is still masked by gnt_q.
      state_d = S_IDLE;
      cnt_d   = 4'd0;
      if (found) begin
        gnt_d[win] = 1'b1;
        reg_d_d    = wdata[int'(win)*WIDTH +: WIDTH];
        reg_ce_d   = 1'b1;
        owner_d    = 3'(win);
        ptr_d      = (int'(win) == N_REQ - 1) ? '0 : win + PW'(1);
        if (lock[win]) begin
          state_d = S_LOCKED;
          cnt_d   = 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      cnt_q    <= 4'd0;
      gnt_q    <= '0;
      reg_d_q  <= '0;
      reg_ce_q <= 1'b0;
      owner_q  <= 3'd0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      reg_d_q  <= reg_d_d;
      reg_ce_q <= reg_ce_d;
      owner_q  <= owner_d;
    end
  end

  assign gnt    = gnt_q;
  assign reg_d  = reg_d_q;
  assign reg_ce = reg_ce_q;
  assign owner  = owner_q;
  assign busy   = (state_q == S_LOCKED);

endmodule

// File: tb/tb_reg_write_arbiter.sv
module tb_reg_write_arbiter;

  localparam int N = 4;
  localparam int W = 16;
  localparam int EW = 4 + W + 1 + 3 + 1;

  localparam logic [15:0] D0 = 16'h1000;
  localparam logic [15:0] D1 = 16'h1001;
  localparam logic [15:0] D2 = 16'h1002;
  localparam logic [15:0] D3 = 16'h1003;

  // clock / reset
  logic         clk = 1'b0;
  logic         clr;
  logic [N-1:0] req;
  logic [N-1:0] lock;
  logic [N*W-1:0] wdata;
  logic [N-1:0] gnt;
  logic [W-1:0] reg_d;
  logic         reg_ce;
  logic [2:0]   owner;
  logic         busy;

  always #5 clk = ~clk;

  reg_write_arbiter #(.N_REQ(N), .WIDTH(W), .MAX_BURST(8)) dut (
    .clk(clk), .clr(clr), .req(req), .lock(lock), .wdata(wdata),
    .gnt(gnt), .reg_d(reg_d), .reg_ce(reg_ce), .owner(owner), .busy(busy)
  );

  // scoreboard
  logic [EW-1:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;
  int n_step = 0;

  typedef struct {
    logic         clr;
    logic [3:0]   req;
    logic [3:0]   lock;
    logic [63:0]  wdata;
    logic [3:0]   gnt;
    logic [15:0]  d;
    logic         ce;
    logic [2:0]   own;
    logic         busy;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [63:0] wd(input logic [15:0] a, input logic [15:0] b,
                                     input logic [15:0] c, input logic [15:0] e);
    return {e, c, b, a};
  endfunction

  function automatic void add(input logic c, input logic [3:0] r, input logic [3:0] l,
                              input logic [63:0] w, input logic [3:0] g,
                              input logic [15:0] d, input logic ce,
                              input logic [2:0] o, input logic b);
    vec_t v;
    v.clr = c; v.req = r; v.lock = l; v.wdata = w;
    v.gnt = g; v.d = d; v.ce = ce; v.own = o; v.busy = b;
    vecs.push_back(v);
  endfunction

  task automatic check_one(input string name, input logic [31:0] got,
                           input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL step%0d %s: got %0h want %0h", n_step, name, got, want);
    end
  endtask

  // driver: apply inputs away from the edge, push the expectation, then
  // sample outputs 1 time unit after the edge and compare against the queue.
  task automatic step(input logic c, input logic [3:0] r, input logic [3:0] l,
                      input logic [63:0] w, input logic [3:0] g,
                      input logic [15:0] d, input logic ce,
                      input logic [2:0] o, input logic b);
    logic [EW-1:0] e;
    @(negedge clk);
    clr = c; req = r; lock = l; wdata = w;
    exp_q.push_back({g, d, ce, o, b});
    @(posedge clk);
    #1;
    n_step++;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL step%0d queue: got empty want entry", n_step);
    end else begin
      e = exp_q.pop_front();
      check_one("gnt",   32'(gnt),    32'(e[EW-1 -: 4]));
      check_one("reg_d", 32'(reg_d),  32'(e[EW-5 -: W]));
      check_one("reg_ce",32'(reg_ce), 32'(e[4]));
      check_one("owner", 32'(owner),  32'(e[3:1]));
      check_one("busy",  32'(busy),   32'(e[0]));
    end
  endtask

  initial begin
    logic [63:0] dw;
    dw    = wd(D0, D1, D2, D3);
    clr   = 1'b1;
    req   = '0;
    lock  = '0;
    wdata = dw;

    // reset with all requesting, then fairness round
    add(1, 4'b1111, 4'b0000, dw, 4'b0000, 16'h0000, 0, 0, 0);
    add(1, 4'b1111, 4'b0000, dw, 4'b0000, 16'h0000, 0, 0, 0);
    add(0, 4'b1111, 4'b0000, dw, 4'b0001, D0, 1, 0, 0);
    add(0, 4'b1110, 4'b0000, dw, 4'b0010, D1, 1, 1, 0);
    add(0, 4'b1100, 4'b0000, dw, 4'b0100, D2, 1, 2, 0);
    add(0, 4'b1000, 4'b0000, dw, 4'b1000, D3, 1, 3, 0);
    add(0, 4'b0000, 4'b0000, dw, 4'b0000, D3, 0, 3, 0);
    // single request, dropped on grant
    add(0, 4'b0100, 4'b0000, wd(D0, D1, 16'hBEEF, D3), 4'b0100, 16'hBEEF, 1, 2, 0);
    add(0, 4'b0000, 4'b0000, dw, 4'b0000, 16'hBEEF, 0, 2, 0);
    // req held after grant: ignored once, then a new request
    add(0, 4'b0001, 4'b0000, dw, 4'b0001, D0, 1, 0, 0);
    add(0, 4'b0001, 4'b0000, dw, 4'b0000, D0, 0, 0, 0);
    add(0, 4'b0001, 4'b0000, dw, 4'b0001, D0, 1, 0, 0);
    add(0, 4'b0000, 4'b0000, dw, 4'b0000, D0, 0, 0, 0);
    // locked burst of requester 1 with requester 3 waiting
    for (int k = 0; k < 8; k++)
      add(0, 4'b1010, 4'b0010, wd(D0, 16'h0010 + 16'(k), D2, D3),
          4'b0010, 16'h0010 + 16'(k), 1, 1, 1);
    add(0, 4'b1010, 4'b0010, wd(D0, 16'h0018, D2, D3), 4'b1000, D3, 1, 3, 0);
    add(0, 4'b1010, 4'b0010, wd(D0, 16'h0018, D2, D3), 4'b0010, 16'h0018, 1, 1, 1);
    add(0, 4'b1010, 4'b0010, wd(D0, 16'h0019, D2, D3), 4'b0010, 16'h0019, 1, 1, 1);
    add(0, 4'b1010, 4'b0010, wd(D0, 16'h001A, D2, D3), 4'b0010, 16'h001A, 1, 1, 1);
    add(0, 4'b1000, 4'b0000, dw, 4'b1000, D3, 1, 3, 0);
    add(0, 4'b0000, 4'b0000, dw, 4'b0000, D3, 0, 3, 0);
    // early release by dropping lock with req still high
    for (int k = 0; k < 3; k++)
      add(0, 4'b0101, 4'b0001, wd(16'hA000 + 16'(k), D1, D2, D3),
          4'b0001, 16'hA000 + 16'(k), 1, 0, 1);
    add(0, 4'b0101, 4'b0000, wd(16'hA003, D1, D2, D3), 4'b0100, D2, 1, 2, 0);
    add(0, 4'b0001, 4'b0000, wd(16'hA003, D1, D2, D3), 4'b0001, 16'hA003, 1, 0, 0);
    add(0, 4'b0000, 4'b0000, dw, 4'b0000, 16'hA003, 0, 0, 0);
    // sole requester hits MAX_BURST: one idle cycle, then regranted
    for (int k = 0; k < 8; k++)
      add(0, 4'b0100, 4'b0100, wd(D0, D1, 16'hC000 + 16'(k), D3),
          4'b0100, 16'hC000 + 16'(k), 1, 2, 1);
    add(0, 4'b0100, 4'b0100, wd(D0, D1, 16'hC008, D3), 4'b0000, 16'hC007, 0, 2, 0);
    add(0, 4'b0100, 4'b0100, wd(D0, D1, 16'hC008, D3), 4'b0100, 16'hC008, 1, 2, 1);
    add(0, 4'b0000, 4'b0000, dw, 4'b0000, 16'hC008, 0, 2, 0);

    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i].clr, vecs[i].req, vecs[i].lock, vecs[i].wdata,
           vecs[i].gnt, vecs[i].d, vecs[i].ce, vecs[i].own, vecs[i].busy);

    // reset during the 4th write of a burst, then a fresh full burst
    for (int k = 0; k < 4; k++)
      step(0, 4'b0001, 4'b0001, wd(16'hE000 + 16'(k), D1, D2, D3),
           4'b0001, 16'hE000 + 16'(k), 1, 0, 1);
    step(1, 4'b0001, 4'b0001, wd(16'hE004, D1, D2, D3), 4'b0000, 16'h0000, 0, 0, 0);
    for (int k = 0; k < 8; k++)
      step(0, 4'b0001, 4'b0001, wd(16'hE004 + 16'(k), D1, D2, D3),
           4'b0001, 16'hE004 + 16'(k), 1, 0, 1);
    step(0, 4'b0001, 4'b0001, wd(16'hE00C, D1, D2, D3), 4'b0000, 16'hE00B, 0, 0, 0);
    step(0, 4'b0001, 4'b0001, wd(16'hE00C, D1, D2, D3), 4'b0001, 16'hE00C, 1, 0, 1);
    step(0, 4'b0000, 4'b0000, dw, 4'b0000, 16'hE00C, 0, 0, 0);

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL leftover: got %0d entries want 0", exp_q.size());
    end

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Round-robin write-port arbiter that shares one `register_16` (its `d`/`ce` inputs) among `N_REQ` requesters in the 8-bit CPU datapath. Each cycle it picks at most one requester, forwards that requester's data to the register with a one-cycle `ce` pulse, and returns a registered grant. An optional `lock` lets a requester hold the register for a bounded burst of back-to-back writes.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `WIDTH`, 16: data width; matches `register_16`.
- `MAX_BURST`, 8: maximum consecutive writes under one lock (1..15).

- `clk`  in  1  rising-edge clock.
- `clr`  in  1  synchronous, active-high reset.
- `req`  in  N_REQ  per-requester write request, level.
- `lock`  in  N_REQ  per-requester burst hold; only meaningful with `req`.
- `wdata`  in  N_REQ*WIDTH  requester i data at bits [i*WIDTH +: WIDTH].
- `gnt`  out  N_REQ  registered one-hot grant; all-zero when idle.
- `reg_d`  out  WIDTH  registered data to `register_16.d`.
- `reg_ce`  out  1  registered enable to `register_16.ce`.
- `owner`  out  3  index of current/last granted requester.
- `busy`  out  1  high while in LOCKED state.

## Operation
- State machine: IDLE, LOCKED.
- Round-robin pointer `ptr` (0..N_REQ-1): search order is ptr, ptr+1, …, wrapping modulo N_REQ.
- Mask: the requester granted at edge E is excluded from arbitration at edge E+1, unless it is in LOCKED continuation. This lets a requester drop `req` on seeing `gnt` without a double write.
- IDLE, at each edge:
  - Winner w = first unmasked i in search order with `req[i]`.
  - If a winner exists: `gnt`=1<<w, `reg_d`=wdata[w], `reg_ce`=1, `owner`=w, `ptr`=(w+1) mod N_REQ.
  - If `lock[w]` is also high: go to LOCKED with burst count=1.
  - If no winner: `gnt`=0, `reg_ce`=0; `reg_d`, `owner` and `ptr` hold.
- LOCKED, at each edge, with o=`owner`:
  - If `req[o]`&`lock[o]` and count<MAX_BURST: `gnt` stays 1<<o, `reg_d`=wdata[o], `reg_ce`=1, count+1.
  - Otherwise (release or count==MAX_BURST): perform IDLE arbitration at this same edge with o masked, and enter IDLE (or LOCKED for the new winner if it locks).
- `busy`=1 exactly while in LOCKED.
- Count width: 4 bits. The comparison with MAX_BURST is unsigned.

## Timing
- Reset: at any edge with `clr`=1, next-cycle values are `gnt`=0, `reg_ce`=0, `reg_d`=0, `owner`=0, `busy`=0, `ptr`=0, count=0, state IDLE, mask cleared.
  - `clr` has priority over every input, including mid-burst.
- Latency: `req`/`wdata` sampled at edge E yields `gnt`/`reg_ce`/`reg_d` valid in the cycle after E. `register_16.q` updates one edge later (2 edges after request).
- `gnt` high for cycle C means that requester's `wdata` sampled at the edge starting C is the value being written.
- Requester rules:
  - Hold `req` and `wdata` stable until `gnt` is observed.
  - `req` still high one cycle after `gnt` (unlocked) is ignored.
  - `req` high two cycles after `gnt` is a new request.
- Simultaneous requests: only the requester nearest `ptr` wins; the others wait with no loss.
- Forced release at MAX_BURST: if the owner is the only requester, it is masked for one edge. There is one idle cycle, then it is regranted.
- Dropping `lock` alone (with `req` still high) ends the burst at that edge. That edge's owner data is not written.

## Test plan
- Reset: `clr`=1 for 2 cycles with all `req`=4'b1111 → `gnt`=0, `reg_ce`=0, `reg_d`=0, `busy`=0 throughout. The first grant after release goes to requester 0.
- Single request: `req[2]`=1, wdata[2]=16'hBEEF for 1 edge, then dropped on `gnt` → `gnt`=4'b0100 for exactly 1 cycle, `reg_d`=16'hBEEF, `reg_ce`=1. `register_16.q`=16'hBEEF 2 edges after the request.
- Fairness: `req`=4'b1111 held, each requester dropping on its own `gnt` → grant order 0,1,2,3, each 1 cycle, no gaps, no repeats.
- Burst: `req[1]`=`lock[1]`=1 held 12 cycles, wdata[1] incrementing from 16'h0010; `req[3]`=1 throughout → 8 consecutive writes 16'h0010…16'h0017 with `busy`=1. `gnt` then moves to 4'b1000 for one cycle, then back to 4'b0010.
- Early release: lock requester 0, drop `lock[0]` after 3 writes while `req[2]`=1 → 3 writes, then `gnt`=4'b0100 at the next cycle, `busy`=0.
- Reset mid-burst: assert `clr` during the 4th write of a locked burst → next cycle all outputs zero, state IDLE. After `clr` drops with `req[0]`=`lock[0]`=1, a fresh burst starts at count 1.
